mc_control_fsm: RTL and testbench

//   Moore/Mealy main control unit that sequences the shared multi-cycle MIPS datapath (PC, IR, MDR, A/B, ALUOut, unified memory).

---
 rtl/mc_ctrl_pkg.sv | 42 ++++
 rtl/mc_retire_counter.sv | 24 ++
 rtl/mc_control_fsm.sv | 185 ++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit: state enum,
// opcode constants and datapath select encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_IF   = 4'd1,
        S_ID   = 4'd2,
        S_MADR = 4'd3,
        S_MRD  = 4'd4,
        S_MWB  = 4'd5,
        S_MWR  = 4'd6,
        S_EXE  = 4'd7,
        S_RWB  = 4'd8,
        S_BEQ  = 4'd9,
        S_JMP  = 4'd10,
        S_AEX  = 4'd11,
        S_AWB  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ASB_B      = 2'b00;
    localparam logic [1:0] ASB_FOUR   = 2'b01;
    localparam logic [1:0] ASB_IMM    = 2'b10;
    localparam logic [1:0] ASB_IMM_SH = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/mc_retire_counter.sv
// Retired-instruction counter: increments once per instr_done pulse and
// wraps modulo 2^CNT_W.
module mc_retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mc_control_fsm.sv
// Main control FSM for the multi-cycle MIPS datapath (IF/ID/EX/MEM/WB with
// memory handshake stalls). Optional BNE decode enabled by MCC_BNE_EN.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             branch_ne,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t r_state;
    state_t w_next;
    logic   w_op_legal;
    logic   r_bne;

    // The branch condition itself is resolved in the datapath's PC-write gating.
    logic w_unused_zero;
    assign w_unused_zero = zero;

    always_comb begin
        w_op_legal = 1'b0;
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: w_op_legal = 1'b1;
`ifdef MCC_BNE_EN
            OP_BNE:                                        w_op_legal = 1'b1;
`endif
            default:                                       w_op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

`ifdef MCC_BNE_EN
    // Opcode is captured on leaving ID so the branch sense stays stable in S_BEQ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bne <= 1'b0;
        end else if (r_state == S_ID) begin
            r_bne <= (opcode == OP_BNE);
        end
    end
`else
    assign r_bne = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: w_next = S_IF;
            S_IF:   w_next = mem_ready ? S_ID : S_IF;
            S_ID: begin
                case (opcode)
                    OP_RTYPE:     w_next = S_EXE;
                    OP_LW, OP_SW: w_next = S_MADR;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_J:         w_next = S_JMP;
                    OP_ADDI:      w_next = S_AEX;
`ifdef MCC_BNE_EN
                    OP_BNE:       w_next = S_BEQ;
`endif
                    default:      w_next = S_IF;
                endcase
            end
            S_MADR: w_next = (opcode == OP_LW) ? S_MRD :
                             (opcode == OP_SW) ? S_MWR : S_IF;
            S_MRD:  w_next = mem_ready ? S_MWB : S_MRD;
            S_MWR:  w_next = mem_ready ? S_IF  : S_MWR;
            S_EXE:  w_next = S_RWB;
            S_AEX:  w_next = S_AWB;
            S_MWB, S_RWB, S_BEQ, S_JMP, S_AWB: w_next = S_IF;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ASB_B;
        alu_op        = ALU_ADD;
        pc_source     = PCS_ALU;
        branch_ne     = 1'b0;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (r_state)
            S_IF: begin
                mem_read  = 1'b1;
                alu_src_b = ASB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_ID: begin
                alu_src_b  = ASB_IMM_SH;
                illegal_op = ~w_op_legal;
            end
            S_MADR, S_AEX: begin
                alu_src_a = 1'b1;
                alu_src_b = ASB_IMM;
            end
            S_MRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MWR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCS_ALUOUT;
                branch_ne     = r_bne;
                instr_done    = 1'b1;
            end
            S_JMP: begin
                pc_write   = 1'b1;
                pc_source  = PCS_JUMP;
                instr_done = 1'b1;
            end
            S_AWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    mc_retire_counter #(.CNT_W(CNT_W)) u_retire (
        .clk   (clk),
        .rst   (rst),
        .i_inc (instr_done),
        .o_cnt (instr_cnt)
    );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed, scoreboard-based bench for mc_control_fsm (CNT_W=4 so the
// retire counter wrap is reachable). Honours MCC_BNE_EN for opcode 000101.
module tb_mc_control_fsm;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       branch_ne, instr_done, illegal_op;
    logic [3:0] instr_cnt;

    mc_control_fsm #(.CNT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .branch_ne     (branch_ne),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .instr_cnt     (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [18:0] w;
        logic [3:0]  c;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic [3:0] exp_cnt = 4'd0;

    // Field order: pcw,pcwc,iord,mrd,mwr,irw,m2r,rdst,rw,asa,asb[2],aop[2],psrc[2],bne,done,ill
    function automatic logic [18:0] mk(input logic pcw, pcwc, io, mrd, mwr, irw, m2r, rdst, rw, asa,
                                       input logic [1:0] asb, aop, psrc, input logic bne, done, ill);
        return {pcw, pcwc, io, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, bne, done, ill};
    endfunction

    function automatic logic [18:0] e_idle();         return '0; endfunction
    function automatic logic [18:0] e_if(input logic r);
        return mk(r,0,0,1,0,r,0,0,0,0,2'b01,2'b00,2'b00,0,0,0);
    endfunction
    function automatic logic [18:0] e_id(input logic ill);
        return mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,ill);
    endfunction
    function automatic logic [18:0] e_madr(); return mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0); endfunction
    function automatic logic [18:0] e_mrd();  return mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0); endfunction
    function automatic logic [18:0] e_mwb();  return mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,1,0); endfunction
    function automatic logic [18:0] e_mwr(input logic r);
        return mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,r,0);
    endfunction
    function automatic logic [18:0] e_exe();  return mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,0); endfunction
    function automatic logic [18:0] e_rwb();  return mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,1,0); endfunction
    function automatic logic [18:0] e_beq(input logic bne);
        return mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,bne,1,0);
    endfunction
    function automatic logic [18:0] e_jmp();  return mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0,1,0); endfunction
    function automatic logic [18:0] e_aex();  return mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0); endfunction
    function automatic logic [18:0] e_awb();  return mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,1,0); endfunction

    function automatic logic [18:0] obs_word();
        return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                branch_ne, instr_done, illegal_op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // One clock cycle: drive inputs, queue the expectation, compare at the
    // falling edge, then advance past the rising edge.
    task automatic cyc(input string tag, input logic [5:0] op, input logic mr, input logic [18:0] expw);
        exp_t e;
        exp_t got;
        opcode    = op;
        mem_ready = mr;
        e.w = expw;
        e.c = exp_cnt;
        sb.push_back(e);
        @(negedge clk);
        n_chk++;
        assert (sb.size() > 0) n_pass++;
        else $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            chk({tag, "_ctl"}, {13'd0, obs_word()}, {13'd0, got.w});
            chk({tag, "_cnt"}, {28'd0, instr_cnt}, {28'd0, got.c});
            chk({tag, "_rdwr"}, {31'd0, mem_read & mem_write}, 32'd0);
            if (got.w[1]) exp_cnt = exp_cnt + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b1;

        cyc("rst0", 6'd0, 1, e_idle());
        cyc("rst1", 6'd0, 1, e_idle());
        rst = 1'b1;
        cyc("idle", 6'd0, 1, e_idle());

        // R-type
        cyc("r_if",  6'b000000, 1, e_if(1));
        cyc("r_id",  6'b000000, 1, e_id(0));
        cyc("r_exe", 6'b000000, 1, e_exe());
        cyc("r_rwb", 6'b000000, 1, e_rwb());

        // lw with two stall cycles in MRD
        cyc("lw_if",   6'b100011, 1, e_if(1));
        cyc("lw_id",   6'b100011, 1, e_id(0));
        cyc("lw_madr", 6'b100011, 1, e_madr());
        cyc("lw_st0",  6'b100011, 0, e_mrd());
        cyc("lw_st1",  6'b100011, 0, e_mrd());
        cyc("lw_mrd",  6'b100011, 1, e_mrd());
        cyc("lw_mwb",  6'b100011, 1, e_mwb());

        zero = 1'b1;
        cyc("beq_if",  6'b000100, 1, e_if(1));
        cyc("beq_id",  6'b000100, 1, e_id(0));
        cyc("beq_ex",  6'b000100, 1, e_beq(0));
        zero = 1'b0;

        cyc("j_if",  6'b000010, 1, e_if(1));
        cyc("j_id",  6'b000010, 1, e_id(0));
        cyc("j_jmp", 6'b000010, 1, e_jmp());

        cyc("ai_if",  6'b001000, 1, e_if(1));
        cyc("ai_id",  6'b001000, 1, e_id(0));
        cyc("ai_aex", 6'b001000, 1, e_aex());
        cyc("ai_awb", 6'b001000, 1, e_awb());

        // Fetch stall
        cyc("if_st",  6'b000000, 0, e_if(0));
        cyc("if_go",  6'b000000, 1, e_if(1));
        cyc("r2_id",  6'b000000, 1, e_id(0));
        cyc("r2_exe", 6'b000000, 1, e_exe());
        cyc("r2_rwb", 6'b000000, 1, e_rwb());

        cyc("ill_if", 6'b111111, 1, e_if(1));
        cyc("ill_id", 6'b111111, 1, e_id(1));

        cyc("bne_if", 6'b000101, 1, e_if(1));
`ifdef MCC_BNE_EN
        cyc("bne_id", 6'b000101, 1, e_id(0));
        cyc("bne_ex", 6'b000101, 1, e_beq(1));
`else
        cyc("bne_id", 6'b000101, 1, e_id(1));
`endif

        cyc("sw_if",   6'b101011, 1, e_if(1));
        cyc("sw_id",   6'b101011, 1, e_id(0));
        cyc("sw_madr", 6'b101011, 1, e_madr());
        cyc("sw_mwr",  6'b101011, 1, e_mwr(1));

        // sw stalled in MWR, then reset asserted mid-cycle
        cyc("sw2_if",   6'b101011, 1, e_if(1));
        cyc("sw2_id",   6'b101011, 1, e_id(0));
        cyc("sw2_madr", 6'b101011, 1, e_madr());
        cyc("sw2_st0",  6'b101011, 0, e_mwr(0));
        mem_ready = 1'b0;
        #2;
        chk("sw2_st1_mwr", {31'd0, mem_write}, 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_mwr", {31'd0, mem_write}, 32'd0);
        chk("arst_ctl", {13'd0, obs_word()}, 32'd0);
        chk("arst_cnt", {28'd0, instr_cnt}, 32'd0);
        exp_cnt = 4'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc("idle2", 6'd0, 1, e_idle());

        // 16 jumps wrap the 4-bit retire counter back to zero
        for (int k = 0; k < 16; k++) begin
            cyc("wj_if",  6'b000010, 1, e_if(1));
            cyc("wj_id",  6'b000010, 1, e_id(0));
            cyc("wj_jmp", 6'b000010, 1, e_jmp());
        end
        cyc("wrap_if", 6'b000000, 1, e_if(1));
        chk("wrap_cnt", {28'd0, instr_cnt}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
